// File: rtl/int_norm_scan.sv
// Leading-one normaliser for int-to-float conversion: absolute value, then a
// fixed five-step binary search for the leading one, with valid/ready on both sides.
module int_norm_scan #(
    parameter bit          SIGNED_IN = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_mag,
    output logic [CNT_W-1:0] out_cnt,
    output logic [31:0]      out_norm,
    output logic             out_sign,
    output logic             out_zero
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CW     = 5;
    localparam int unsigned STEP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        SRCH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   w;
    logic [CW-1:0]       cnt;
    logic [STEP_W-1:0]   step;

    logic [DATA_W-1:0]   mag_c;
    logic                neg_c;
    logic [DATA_W-1:0]   w_nxt_c;
    logic [CW-1:0]       cnt_nxt_c;

    // Two's-complement magnitude; INT_MIN wraps to itself, i.e. 0x80000000.
    always_comb begin
        neg_c = SIGNED_IN && data_q[DATA_W-1];
        mag_c = neg_c ? (~data_q + 32'd1) : data_q;
    end

    // One binary-search step; step size halves from 16 down to 1.
    always_comb begin
        w_nxt_c   = w;
        cnt_nxt_c = cnt;
        case (step)
            3'd0: if (w[31:16] == 16'd0) begin
                w_nxt_c   = w << 16;
                cnt_nxt_c = cnt - 5'd16;
            end
            3'd1: if (w[31:24] == 8'd0) begin
                w_nxt_c   = w << 8;
                cnt_nxt_c = cnt - 5'd8;
            end
            3'd2: if (w[31:28] == 4'd0) begin
                w_nxt_c   = w << 4;
                cnt_nxt_c = cnt - 5'd4;
            end
            3'd3: if (w[31:30] == 2'd0) begin
                w_nxt_c   = w << 2;
                cnt_nxt_c = cnt - 5'd2;
            end
            default: if (w[31] == 1'b0) begin
                w_nxt_c   = w << 1;
                cnt_nxt_c = cnt - 5'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_q    <= '0;
            w         <= '0;
            cnt       <= '0;
            step      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_cnt   <= '0;
            out_norm  <= '0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
        end else if (flush && (state != IDLE)) begin
            // Abort: drop whatever is in flight, including a pending result.
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        data_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= ABS;
                    end
                end
                ABS: begin
                    w        <= mag_c;
                    out_mag  <= mag_c;
                    out_sign <= neg_c;
                    out_zero <= (data_q == 32'd0);
                    cnt      <= 5'd31;
                    step     <= '0;
                    state    <= SRCH;
                end
                SRCH: begin
                    w    <= w_nxt_c;
                    cnt  <= cnt_nxt_c;
                    step <= step + 3'd1;
                    if (step == 3'd4) begin
                        out_norm  <= w_nxt_c;
                        out_cnt   <= CNT_W'(cnt_nxt_c);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_norm_scan.sv
// Directed bench for int_norm_scan: a signed and an unsigned instance share stimulus.
module tb_int_norm_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b0;

    logic        s_in_ready, s_out_valid, s_out_sign, s_out_zero;
    logic [31:0] s_out_mag, s_out_norm;
    logic [7:0]  s_out_cnt;
    logic        u_in_ready, u_out_valid, u_out_sign, u_out_zero;
    logic [31:0] u_out_mag, u_out_norm;
    logic [7:0]  u_out_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    int_norm_scan #(.SIGNED_IN(1'b1), .CNT_W(8)) u_s (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_mag(s_out_mag), .out_cnt(s_out_cnt), .out_norm(s_out_norm),
        .out_sign(s_out_sign), .out_zero(s_out_zero)
    );

    int_norm_scan #(.SIGNED_IN(1'b0), .CNT_W(8)) u_u (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
        .out_valid(u_out_valid), .out_ready(out_ready),
        .out_mag(u_out_mag), .out_cnt(u_out_cnt), .out_norm(u_out_norm),
        .out_sign(u_out_sign), .out_zero(u_out_zero)
    );

    // Present one operand; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [31:0] d);
        int n = 0;
        while (!s_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_in_ready) begin
            total++; bad++;
            $display("FAIL start_op: in_ready never rose, got %0b want 1", s_in_ready);
        end
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid; a timeout is a failure.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!s_out_valid) begin
            total++; bad++;
            $display("FAIL wait_valid: out_valid timeout, got %0b want 1", s_out_valid);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %0b want 1", s_in_ready); end
        total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %0b want 0", s_out_valid); end
        total++; if ({s_out_mag, s_out_norm, s_out_cnt, s_out_sign, s_out_zero} !== 74'd0) begin
            bad++; $display("FAIL rst_outputs got mag=%h norm=%h cnt=%0d sign=%0b zero=%0b want all 0",
                            s_out_mag, s_out_norm, s_out_cnt, s_out_sign, s_out_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_one();
        int lat;
        start_op(32'h0000_0001);
        wait_valid(lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL one_latency got %0d want 6", lat); end
        total++; if (s_out_mag !== 32'd1) begin bad++; $display("FAIL one_mag got %h want 00000001", s_out_mag); end
        total++; if (s_out_cnt !== 8'd0) begin bad++; $display("FAIL one_cnt got %0d want 0", s_out_cnt); end
        total++; if (s_out_norm !== 32'h8000_0000) begin bad++; $display("FAIL one_norm got %h want 80000000", s_out_norm); end
        total++; if ({s_out_sign, s_out_zero} !== 2'b00) begin bad++; $display("FAIL one_flags got %b want 00", {s_out_sign, s_out_zero}); end
        release_result();
    endtask

    task automatic test_neg();
        int lat;
        start_op(32'hFFFF_FFFB);
        wait_valid(lat);
        total++; if (s_out_mag !== 32'd5) begin bad++; $display("FAIL neg_mag got %h want 00000005", s_out_mag); end
        total++; if (s_out_cnt !== 8'd2) begin bad++; $display("FAIL neg_cnt got %0d want 2", s_out_cnt); end
        total++; if (s_out_norm !== 32'hA000_0000) begin bad++; $display("FAIL neg_norm got %h want a0000000", s_out_norm); end
        total++; if (s_out_sign !== 1'b1) begin bad++; $display("FAIL neg_sign got %0b want 1", s_out_sign); end
        total++; if (u_out_mag !== 32'hFFFF_FFFB) begin bad++; $display("FAIL uns_mag got %h want fffffffb", u_out_mag); end
        total++; if (u_out_cnt !== 8'd31) begin bad++; $display("FAIL uns_cnt got %0d want 31", u_out_cnt); end
        total++; if (u_out_sign !== 1'b0) begin bad++; $display("FAIL uns_sign got %0b want 0", u_out_sign); end
        total++; if (u_out_norm !== 32'hFFFF_FFFB) begin bad++; $display("FAIL uns_norm got %h want fffffffb", u_out_norm); end
        release_result();
    endtask

    task automatic test_intmin_zero();
        int lat;
        start_op(32'h8000_0000);
        wait_valid(lat);
        total++; if (s_out_mag !== 32'h8000_0000) begin bad++; $display("FAIL min_mag got %h want 80000000", s_out_mag); end
        total++; if (s_out_cnt !== 8'd31) begin bad++; $display("FAIL min_cnt got %0d want 31", s_out_cnt); end
        total++; if (s_out_norm !== 32'h8000_0000) begin bad++; $display("FAIL min_norm got %h want 80000000", s_out_norm); end
        total++; if ({s_out_sign, s_out_zero} !== 2'b10) begin bad++; $display("FAIL min_flags got %b want 10", {s_out_sign, s_out_zero}); end
        release_result();
        start_op(32'h0000_0000);
        wait_valid(lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL zero_latency got %0d want 6", lat); end
        total++; if (s_out_zero !== 1'b1) begin bad++; $display("FAIL zero_flag got %0b want 1", s_out_zero); end
        total++; if (s_out_cnt !== 8'd0) begin bad++; $display("FAIL zero_cnt got %0d want 0", s_out_cnt); end
        total++; if ({s_out_norm, s_out_mag} !== 64'd0) begin bad++; $display("FAIL zero_norm_mag got %h %h want 0 0", s_out_norm, s_out_mag); end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(32'h0001_2345);
        wait_valid(lat);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_out_cnt !== 8'd16 ||
                s_out_norm !== 32'h91A2_8000 || s_out_mag !== 32'h0001_2345) begin
                bad++;
                $display("FAIL bp_hold[%0d] got v=%0b rdy=%0b cnt=%0d norm=%h mag=%h want 1 0 16 91a28000 00012345",
                         i, s_out_valid, s_in_ready, s_out_cnt, s_out_norm, s_out_mag);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop_valid got %0b want 0", s_out_valid); end
        total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready got %0b want 1", s_in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(32'h0000_0100);
        in_valid = 1'b1;
        in_data  = 32'h7FFF_FFFF;
        wait_valid(lat);
        total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy_ready got %0b want 0", s_in_ready); end
        total++; if (s_out_cnt !== 8'd8 || s_out_mag !== 32'h100) begin
            bad++; $display("FAIL b2b_first got cnt=%0d mag=%h want 8 00000100", s_out_cnt, s_out_mag);
        end
        release_result();
        total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back got %0b want 1", s_in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got %0b want 0", s_in_ready); end
        wait_valid(lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL b2b_latency got %0d want 6", lat); end
        total++; if (s_out_cnt !== 8'd30 || s_out_norm !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL b2b_second got cnt=%0d norm=%h want 30 fffffffe", s_out_cnt, s_out_norm);
        end
        release_result();
    endtask

    task automatic test_flush();
        int lat;
        logic seen;
        start_op(32'h0000_1234);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_srch got rdy=%0b v=%0b want 1 0", s_in_ready, s_out_valid);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (s_out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_valid got %0b want 0", seen); end
        // flush in IDLE must block acceptance
        in_data  = 32'h0000_0040;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL flush_idle got %0b want 1", s_in_ready); end
        // flush together with out_ready in DONE
        start_op(32'h0000_0040);
        wait_valid(lat);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        total++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_done got v=%0b rdy=%0b want 0 1", s_out_valid, s_in_ready);
        end
    endtask

    task automatic test_reset_mid();
        start_op(32'h00F0_0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({s_out_mag, s_out_norm, s_out_cnt, s_out_sign, s_out_zero, s_out_valid} !== 75'd0) begin
            bad++; $display("FAIL rst_mid_outputs got mag=%h norm=%h cnt=%0d v=%0b want all 0",
                            s_out_mag, s_out_norm, s_out_cnt, s_out_valid);
        end
        total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got %0b want 1", s_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_one();
        test_neg();
        test_intmin_zero();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_norm_scan.md
Name: int_norm_scan

Overview:
- Multi-cycle leading-one normaliser that sits directly upstream of the integer-to-float packer in the FPU convert path (cvt.s.w).
- Takes a 32-bit integer and produces four things: its magnitude, the bit index of the leading one (cnt), a sign flag and a zero flag.
- The packer builds the float from these: exponent = cnt+127, mantissa = magnitude shifted left by (32-cnt), bits [31:9].
- Uses a 5-step binary search with valid/ready handshakes on both sides.

Parameters:
- SIGNED_IN, 1: 1 = treat in_data as two's complement; 0 = treat as unsigned (sign forced to 0).
- CNT_W, 8: width of out_cnt; must be >= 5.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous abort (pipeline flush / exception).
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept an operand.
- in_data, input, 32: integer operand.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- out_mag, output, 32: |in_data| (0x80000000 for INT_MIN).
- out_cnt, output, CNT_W: index of the most-significant 1 in out_mag, 0..31.
- out_norm, output, 32: out_mag shifted left so bit31 = 1 (0 when zero).
- out_sign, output, 1: sign of in_data (0 if SIGNED_IN=0).
- out_zero, output, 1: in_data == 0.

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready=1; out_valid=0; out_mag, out_cnt, out_norm, out_sign, out_zero all 0. Asserting reset mid-operation discards the operation.
- States: IDLE, ABS, SRCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && !flush: latch in_data; go to ABS.
  - in_ready is a registered function of state, not combinationally dependent on in_valid.
- ABS (1 cycle):
  - mag = (SIGNED_IN && in[31]) ? (~in+1) : in, in 32-bit wrap arithmetic; INT_MIN gives 0x80000000.
  - Load w=mag, out_mag=mag, out_sign, out_zero=(in==0), cnt=31, step counter=0.
  - Go to SRCH.
- SRCH (exactly 5 cycles, step sizes 16,8,4,2,1):
  - For step size s: if w[31:32-s]==0, then w <<= s and cnt -= s.
  - After the fifth step: out_norm=w, out_cnt=cnt (zero-extended to CNT_W), out_valid=1, go to DONE.
  - Zero input takes the same path: all shifts happen, cnt ends at 0, out_norm=0, out_zero=1. Fixed latency, no early exit.
- DONE:
  - out_valid=1; all out_* held stable while out_ready=0.
  - On out_ready: out_valid drops at that edge; go to IDLE; in_ready=1 the following cycle.
  - No same-cycle result/accept overlap (throughput one op per 8 cycles minimum).
- Latency: input accepted at edge k; out_valid=1 after edge k+6.
- flush:
  - In any non-IDLE state: return to IDLE on the next edge, out_valid=0, result discarded.
  - In IDLE: suppresses acceptance even if in_valid=1.
  - flush and out_ready together in DONE: the result counts as discarded (same final state).
- Invariants:
  - out_zero=0 implies out_norm[31]=1 and out_mag >> out_cnt == 1.
  - out_mag never changes while out_valid=1.
- Widths: cnt arithmetic is 5-bit internally, with no underflow (the total shift is at most 31).

Test Plan:
- in_data=0x00000001 -> after 6 edges: out_mag=1, out_cnt=0, out_norm=0x80000000, out_sign=0, out_zero=0.
- in_data=0xFFFFFFFB (-5) -> out_mag=5, out_cnt=2, out_norm=0xA0000000, out_sign=1; with SIGNED_IN=0 -> out_mag=0xFFFFFFFB, out_cnt=31, out_sign=0.
- in_data=0x80000000 (INT_MIN) -> out_mag=0x80000000, out_cnt=31, out_norm=0x80000000, out_sign=1; in_data=0 -> out_zero=1, out_cnt=0, out_norm=0.
- Backpressure: in_data=0x00012345 with out_ready low for 3 cycles after out_valid -> out_cnt=16, out_norm=0x91A28000, outputs stable, in_ready=0; then out_ready=1 -> out_valid=0, in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with 0x00000100 then 0x7FFFFFFF -> second operand accepted only once in_ready returns; results cnt=8 then cnt=30, in order.
- flush in the 3rd SRCH cycle -> IDLE next edge, no out_valid; rst_n pulsed low mid-SRCH -> all outputs 0 immediately, in_ready=1.
